// File: rtl/mha_pkg.sv
// Shared types and width helpers for the multi-head attention phase scheduler.
package mha_pkg;

    localparam int MAX_TOKENS_DEF = 256;
    localparam int MAX_HEADS_DEF  = 16;
    localparam int MAX_OUTST_DEF  = 4;

    function automatic int tok_w(input int max_tokens);
        return (max_tokens > 2) ? $clog2(max_tokens) : 1;
    endfunction

    function automatic int head_w(input int max_heads);
        return (max_heads > 2) ? $clog2(max_heads) : 1;
    endfunction

    typedef enum logic [2:0] {
        OP_NONE    = 3'd0,
        OP_PROJ    = 3'd1,
        OP_SCORE   = 3'd2,
        OP_SOFTMAX = 3'd3,
        OP_OUTPROJ = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_PROJ    = 3'd1,
        PH_SCORE   = 3'd2,
        PH_SOFTMAX = 3'd3,
        PH_OUTPROJ = 3'd4
    } phase_e;

    typedef enum logic {
        SUB_ISSUE = 1'b0,
        SUB_WAIT  = 1'b1
    } sub_e;

    function automatic op_e phase_op(input phase_e ph);
        case (ph)
            PH_PROJ:    return OP_PROJ;
            PH_SCORE:   return OP_SCORE;
            PH_SOFTMAX: return OP_SOFTMAX;
            PH_OUTPROJ: return OP_OUTPROJ;
            default:    return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mha_credit_counter.sv
// Outstanding-command tracker: counts accepted commands not yet answered.
module mha_credit_counter #(
    parameter int MAX_OUTST = 4,
    parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic             full_o,
    output logic             empty_o,
    output logic             underflow_o,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign full_o      = (count_q == CNT_W'(MAX_OUTST));
    assign empty_o     = (count_q == '0);
    assign underflow_o = dec_i && empty_o;
    assign count_o     = count_q;

    // A response with nothing in flight is flagged but never wraps the count.
    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i) begin
            count_d = count_q + CNT_W'(1);
        end else if (dec_i && !inc_i && !empty_o) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mha_head_scheduler.sv
// Walks the MHA engine through PROJ/SCORE/SOFTMAX per head, then OUTPROJ,
// issuing one row command at a time with a drain barrier between phases.
//   phase   | meaning
//   IDLE    | ready, waiting for init
//   PROJ    | Q/K/V rows for current head
//   SCORE   | QK^T rows for current head
//   SOFTMAX | weight rows for current head
//   OUTPROJ | Wo pass over all tokens, head fixed at 0
module mha_head_scheduler
    import mha_pkg::*;
#(
    parameter int MAX_TOKENS = MAX_TOKENS_DEF,
    parameter int MAX_HEADS  = MAX_HEADS_DEF,
    parameter int MAX_OUTST  = MAX_OUTST_DEF,
    parameter int TOK_W      = tok_w(MAX_TOKENS),
    parameter int HEAD_W     = head_w(MAX_HEADS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              init,
    output logic              ready,
    output logic              done,
    input  logic [TOK_W-1:0]  cfg_n_tokens,
    input  logic [HEAD_W-1:0] cfg_n_heads,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [2:0]        cmd_op,
    output logic [HEAD_W-1:0] cmd_head,
    output logic [TOK_W-1:0]  cmd_row,
    input  logic              rsp_valid,
    output logic              err
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    phase_e            phase_q, phase_d;
    sub_e              sub_q, sub_d;
    logic [HEAD_W-1:0] head_q, head_d;
    logic [TOK_W-1:0]  row_q, row_d;
    logic [TOK_W-1:0]  n_q, n_d;
    logic [HEAD_W-1:0] h_q, h_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              cnt_full;
    logic              cnt_empty;
    logic              cnt_underflow;
    logic [CNT_W-1:0]  cnt_count;

    logic              xfer;
    logic              last_row;
    logic              last_head;
    logic              drain_next;

    mha_credit_counter #(
        .MAX_OUTST (MAX_OUTST),
        .CNT_W     (CNT_W)
    ) u_credit (
        .clk         (clk),
        .reset_n     (reset_n),
        .inc_i       (xfer),
        .dec_i       (rsp_valid),
        .full_o      (cnt_full),
        .empty_o     (cnt_empty),
        .underflow_o (cnt_underflow),
        .count_o     (cnt_count)
    );

    // Full can only be reached through a transfer, so gating on it never
    // withdraws a command that is still waiting for cmd_ready.
    assign cmd_valid = (phase_q != PH_IDLE) && (sub_q == SUB_ISSUE) && !cnt_full;
    assign xfer      = cmd_valid && cmd_ready;
    assign last_row  = (row_q == n_q - TOK_W'(1));
    assign last_head = (head_q == h_q - HEAD_W'(1));

    // No commands issue while waiting, so the count only falls in that state.
    assign drain_next = cnt_empty || ((cnt_count == CNT_W'(1)) && rsp_valid);

    assign ready    = (phase_q == PH_IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign cmd_op   = phase_op(phase_q);
    assign cmd_head = head_q;
    assign cmd_row  = row_q;

    always_comb begin
        phase_d = phase_q;
        sub_d   = sub_q;
        head_d  = head_q;
        row_d   = row_q;
        n_d     = n_q;
        h_d     = h_q;
        done_d  = 1'b0;
        err_d   = err_q | cnt_underflow;

        case (phase_q)
            PH_IDLE: begin
                if (init) begin
                    n_d     = (cfg_n_tokens == '0) ? TOK_W'(1) : cfg_n_tokens;
                    h_d     = (cfg_n_heads == '0) ? HEAD_W'(1) : cfg_n_heads;
                    phase_d = PH_PROJ;
                    sub_d   = SUB_ISSUE;
                    head_d  = '0;
                    row_d   = '0;
                end
            end
            default: begin
                if (sub_q == SUB_ISSUE) begin
                    if (xfer) begin
                        if (last_row) begin
                            sub_d = SUB_WAIT;
                        end else begin
                            row_d = row_q + TOK_W'(1);
                        end
                    end
                end else if (drain_next) begin
                    sub_d = SUB_ISSUE;
                    row_d = '0;
                    case (phase_q)
                        PH_PROJ:  phase_d = PH_SCORE;
                        PH_SCORE: phase_d = PH_SOFTMAX;
                        PH_SOFTMAX: begin
                            if (last_head) begin
                                phase_d = PH_OUTPROJ;
                                head_d  = '0;
                            end else begin
                                phase_d = PH_PROJ;
                                head_d  = head_q + HEAD_W'(1);
                            end
                        end
                        default: begin
                            phase_d = PH_IDLE;
                            done_d  = 1'b1;
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= PH_IDLE;
            sub_q   <= SUB_ISSUE;
            head_q  <= '0;
            row_q   <= '0;
            n_q     <= TOK_W'(1);
            h_q     <= HEAD_W'(1);
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            sub_q   <= sub_d;
            head_q  <= head_d;
            row_q   <= row_d;
            n_q     <= n_d;
            h_q     <= h_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mha_head_scheduler.sv
// Directed bench for mha_head_scheduler: engine model with in-order responses.
module tb_mha_head_scheduler;

    logic       clk;
    logic       reset_n;
    logic       init;
    logic       ready;
    logic       done;
    logic [7:0] cfg_n_tokens;
    logic [3:0] cfg_n_heads;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_head;
    logic [7:0] cmd_row;
    logic       rsp_valid;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int log_pay [128];
    int log_cyc [128];
    int rsp_cyc [128];
    int n_cmds;
    int rsp_idx;
    int rsp_q[$];
    int done_cnt;
    int done_cyc;
    int last_rsp_cyc;
    int hold_until;
    int delay_idx;
    int delay_long;
    int rmode;
    bit stall_q;
    int stall_pay;

    mha_head_scheduler dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .init         (init),
        .ready        (ready),
        .done         (done),
        .cfg_n_tokens (cfg_n_tokens),
        .cfg_n_heads  (cfg_n_heads),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_head     (cmd_head),
        .cmd_row      (cmd_row),
        .rsp_valid    (rsp_valid),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pack(input int op, input int hd, input int r);
        return op * 65536 + hd * 256 + r;
    endfunction

    function automatic int cur_pay();
        return pack(int'(cmd_op), int'(cmd_head), int'(cmd_row));
    endfunction

    // One clock: sample after the edge, play the engine side for this cycle.
    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check_val("ready_with_done", int'(ready), 1);
        end
        cmd_ready = (rmode == 1) ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (stall_q) begin
            check_val("hold_valid", int'(cmd_valid), 1);
            check_val("hold_payload", cur_pay(), stall_pay);
        end
        if (cmd_valid && cmd_ready) begin
            if (n_cmds < 128) begin
                log_pay[n_cmds] = cur_pay();
                log_cyc[n_cmds] = cyc;
            end
            rsp_q.push_back(cyc + ((n_cmds == delay_idx) ? delay_long : 1));
            n_cmds++;
        end
        stall_q   = cmd_valid && !cmd_ready;
        stall_pay = cur_pay();
        rsp_valid = 1'b0;
        if (rsp_q.size() > 0 && rsp_q[0] <= cyc && cyc >= hold_until) begin
            rsp_valid = 1'b1;
            void'(rsp_q.pop_front());
            if (rsp_idx < 128) rsp_cyc[rsp_idx] = cyc;
            rsp_idx++;
            last_rsp_cyc = cyc;
        end
    endtask

    task automatic start_job(input int n, input int h);
        n_cmds       = 0;
        rsp_idx      = 0;
        done_cnt     = 0;
        done_cyc     = -1;
        last_rsp_cyc = -1;
        rsp_q.delete();
        cfg_n_tokens = 8'(n);
        cfg_n_heads  = 4'(h);
        init         = 1'b1;
        cycle();
        init = 1'b0;
        check_val("ready_low", int'(ready), 0);
        check_val("first_valid", int'(cmd_valid), 1);
        check_val("first_cmd", cur_pay(), pack(1, 0, 0));
    endtask

    task automatic run_until_done(input int exp_cmds, input int budget);
        int lim;
        lim = cyc + budget;
        while (done_cnt == 0 && cyc < lim) cycle();
        repeat (3) cycle();
        check_val("done_pulses", done_cnt, 1);
        check_val("done_latency", done_cyc, last_rsp_cyc + 1);
        check_val("cmd_count", n_cmds, exp_cmds);
        check_val("ready_idle", int'(ready), 1);
    endtask

    task automatic check_order(input int n, input int h);
        int idx;
        idx = 0;
        for (int hd = 0; hd < h; hd++) begin
            for (int op = 1; op <= 3; op++) begin
                for (int r = 0; r < n; r++) begin
                    check_val($sformatf("order[%0d]", idx),
                              (idx < n_cmds && idx < 128) ? log_pay[idx] : -1, pack(op, hd, r));
                    idx++;
                end
            end
        end
        for (int r = 0; r < n; r++) begin
            check_val($sformatf("order[%0d]", idx),
                      (idx < n_cmds && idx < 128) ? log_pay[idx] : -1, pack(4, 0, r));
            idx++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"}, int'(ready), 1);
        check_val({tag, "_done"}, int'(done), 0);
        check_val({tag, "_valid"}, int'(cmd_valid), 0);
        check_val({tag, "_op"}, int'(cmd_op), 0);
        check_val({tag, "_head"}, int'(cmd_head), 0);
        check_val({tag, "_row"}, int'(cmd_row), 0);
        check_val({tag, "_err"}, int'(err), 0);
    endtask

    initial begin
        int lim;
        reset_n      = 1'b0;
        init         = 1'b0;
        cfg_n_tokens = '0;
        cfg_n_heads  = '0;
        cmd_ready    = 1'b0;
        rsp_valid    = 1'b0;
        rmode        = 0;
        hold_until   = 0;
        delay_idx    = -1;
        delay_long   = 0;
        stall_q      = 1'b0;
        stall_pay    = 0;
        n_cmds       = 0;
        rsp_idx      = 0;
        done_cnt     = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // n=3, H=2, always ready, 1-cycle responses
        start_job(3, 2);
        run_until_done(21, 200);
        check_order(3, 2);
        check_val("err_clean", int'(err), 0);

        // responses withheld: at most four in flight, then resume
        hold_until = cyc + 20;
        start_job(6, 1);
        repeat (17) cycle();
        check_val("withheld_xfers", n_cmds, 4);
        check_val("withheld_valid", int'(cmd_valid), 0);
        run_until_done(24, 300);
        check_order(6, 1);
        hold_until = 0;

        // random backpressure
        rmode = 1;
        start_job(3, 2);
        run_until_done(21, 400);
        check_order(3, 2);
        rmode = 0;

        // last PROJ response late: SCORE must wait for it
        delay_idx  = 2;
        delay_long = 10;
        start_job(3, 1);
        run_until_done(12, 200);
        check_order(3, 1);
        check_val("late_rsp_cycle", rsp_cyc[2], log_cyc[2] + 10);
        check_val("score_after_rsp", log_cyc[3], rsp_cyc[2] + 1);
        delay_idx = -1;

        // reset in the middle of SCORE
        start_job(3, 2);
        lim = cyc + 100;
        while (n_cmds < 4 && cyc < lim) cycle();
        check_val("reached_score", (n_cmds >= 4) ? log_pay[3] : -1, pack(2, 0, 0));
        #2;
        reset_n   = 1'b0;
        rsp_valid = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rsp_q.delete();
        stall_q = 1'b0;
        start_job(3, 2);
        run_until_done(21, 200);
        check_order(3, 2);
        check_val("err_after_restart", int'(err), 0);

        // stray response while idle raises sticky err
        rsp_valid = 1'b1;
        cycle();
        check_val("err_set", int'(err), 1);
        repeat (5) cycle();
        check_val("err_sticky", int'(err), 1);

        // zero token count runs as n=1; init while busy is ignored
        start_job(0, 2);
        cycle();
        cfg_n_tokens = 8'd5;
        cfg_n_heads  = 4'd3;
        init         = 1'b1;
        cycle();
        init = 1'b0;
        run_until_done(7, 200);
        check_order(1, 2);
        check_val("err_still_set", int'(err), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
